// File: rtl/cache_control_if.sv
// CPU/datapath/pmem control bundle for the two-way cache controller.
// Optional perf counter wires appear with CACHE_CTRL_PERF_EN.
interface cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic [1:0]  hit;
  logic        lru_out;
  logic [1:0]  dirty_out;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;
  logic        pmem_addr_sel;
  logic [1:0]  data_load;
  logic [1:0]  tag_load;
  logic [1:0]  valid_load;
  logic [1:0]  dirty_load;
  logic        data_sel;
  logic        dirty_in;
  logic        lru_load;
  logic        lru_in;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  modport master (
    output mem_read, mem_write, hit, lru_out,
    output dirty_out, pmem_resp,
    input  mem_resp, pmem_read, pmem_write,
    input  pmem_addr_sel, data_load, tag_load,
    input  valid_load, dirty_load, data_sel,
    input  dirty_in, lru_load, lru_in
`ifdef CACHE_CTRL_PERF_EN
    , input hit_count, miss_count
`endif
  );

  modport slave (
    input  mem_read, mem_write, hit, lru_out,
    input  dirty_out, pmem_resp,
    output mem_resp, pmem_read, pmem_write,
    output pmem_addr_sel, data_load, tag_load,
    output valid_load, dirty_load, data_sel,
    output dirty_in, lru_load, lru_in
`ifdef CACHE_CTRL_PERF_EN
    , output hit_count, miss_count
`endif
  );
endinterface

// File: rtl/cache_control.sv
// Two-way write-back cache controller: IDLE/CHECK/WRITEBACK/FETCH.
// Define CACHE_CTRL_PERF_EN to add hit/miss performance counters.
module cache_control #(
  parameter int s_index = 3
) (
  input logic           clk,
  input logic           rst,
  cache_control_if.slave bus
);
  if (s_index < 1) begin : g_index_check
    $error("s_index must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    FETCH
  } state_t;

  state_t state;
  state_t state_next;
  logic   victim;
  logic   victim_next;
  logic   req;
  logic   way;
  logic   any_hit;
  logic [1:0] way_mask;
  logic [1:0] victim_mask;

  assign req         = bus.mem_read | bus.mem_write;
  assign any_hit     = |bus.hit;
  // hit=11 resolves to way 0
  assign way         = ~bus.hit[0];
  assign way_mask    = way ? 2'b10 : 2'b01;
  assign victim_mask = victim ? 2'b10 : 2'b01;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state  <= state_next;
      victim <= victim_next;
    end
  end

  always_comb begin
    state_next        = state;
    victim_next       = victim;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.data_load     = 2'b00;
    bus.tag_load      = 2'b00;
    bus.valid_load    = 2'b00;
    bus.dirty_load    = 2'b00;
    bus.data_sel      = 1'b0;
    bus.dirty_in      = 1'b0;
    bus.lru_load      = 1'b0;
    bus.lru_in        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) state_next = CHECK;
      end
      CHECK: begin
        state_next = IDLE;
        if (req && any_hit) begin
          bus.mem_resp = 1'b1;
          bus.lru_load = 1'b1;
          bus.lru_in   = ~way;
          // a write wins over a simultaneous read
          if (bus.mem_write) begin
            bus.data_load  = way_mask;
            bus.dirty_load = way_mask;
            bus.dirty_in   = 1'b1;
          end
        end else if (req) begin
          victim_next = bus.lru_out;
          state_next  = bus.dirty_out[bus.lru_out]
                      ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) state_next = FETCH;
      end
      FETCH: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.data_load  = victim_mask;
          bus.tag_load   = victim_mask;
          bus.valid_load = victim_mask;
          bus.dirty_load = victim_mask;
          bus.data_sel   = 1'b1;
          state_next     = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic        after_fill;
  logic        check_hit;
  logic        check_miss;

  assign check_hit  = (state == CHECK) && req && any_hit;
  assign check_miss = (state == CHECK) && req && !any_hit;

  // the re-check after a fill is part of the miss, not a new hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= (state == FETCH);
      if (check_hit && !after_fill) hit_cnt <= hit_cnt + 32'd1;
      if (check_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`endif
endmodule

// File: tb/tb_cache_control.sv
// Directed and randomized checks of the cache controller against
// a transaction-level two-way set model.
module tb_cache_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_control_if bus ();

  cache_control #(.s_index(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       dir;
  logic       env_clr;
  logic [1:0] d_hit;
  logic [1:0] d_dirty;
  logic       d_lru;
  logic [7:0] cur_tag;
  logic [7:0] wdata;

  logic [1:0] e_valid;
  logic [1:0] e_dirty;
  logic       e_lru;
  logic [7:0] e_tag [2];
  logic [7:0] e_data [2];

  logic [1:0] r_valid;
  logic [1:0] r_dirty;
  logic       r_lru;
  logic [7:0] r_tag [2];
  logic [7:0] r_data [2];
  int         r_hits;
  int         r_misses;

  function automatic logic [7:0] line(input logic [7:0] t);
    return t ^ 8'h5a;
  endfunction

  // datapath stand-in: arrays written by the controller's loads
  always_comb begin
    bus.hit       = d_hit;
    bus.lru_out   = d_lru;
    bus.dirty_out = d_dirty;
    if (!dir) begin
      bus.hit = {e_valid[1] && (e_tag[1] == cur_tag),
                 e_valid[0] && (e_tag[0] == cur_tag)};
      bus.lru_out   = e_lru;
      bus.dirty_out = e_dirty;
    end
  end

  always @(posedge clk) begin
    if (env_clr) begin
      e_valid <= 2'b00;
      e_dirty <= 2'b00;
      e_lru   <= 1'b0;
      for (int w = 0; w < 2; w++) begin
        e_tag[w]  <= 8'h00;
        e_data[w] <= 8'h00;
      end
    end else if (!dir) begin
      for (int w = 0; w < 2; w++) begin
        if (bus.tag_load[w]) e_tag[w] <= cur_tag;
        if (bus.valid_load[w]) e_valid[w] <= 1'b1;
        if (bus.dirty_load[w]) e_dirty[w] <= bus.dirty_in;
        if (bus.data_load[w])
          e_data[w] <= bus.data_sel ? line(cur_tag) : wdata;
      end
      if (bus.lru_load) e_lru <= bus.lru_in;
    end
  end

  function automatic logic [15:0] o(
    input bit resp, pr, pw, asel, dsel, din, ll, li,
    input logic [1:0] dl, tl, vl, yl);
    return {resp, pr, pw, asel, dsel, din, ll, li,
            dl, tl, vl, yl};
  endfunction

  function automatic logic [15:0] outs();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write,
            bus.pmem_addr_sel, bus.data_sel, bus.dirty_in,
            bus.lru_load, bus.lru_in, bus.data_load,
            bus.tag_load, bus.valid_load, bus.dirty_load};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic txn(input logic [7:0] t, input bit wr,
                     input logic [7:0] wd);
    int hw, cyc, resp_cyc, fill_cyc, nwb, nfill, dly, wcnt;
    bit miss, wb, done;
    hw = -1;
    for (int w = 1; w >= 0; w--)
      if (r_valid[w] && r_tag[w] == t) hw = w;
    miss = (hw < 0);
    wb   = miss && r_dirty[r_lru];
    if (miss) begin
      hw = int'(r_lru);
      r_tag[hw]   = t;
      r_valid[hw] = 1'b1;
      r_dirty[hw] = 1'b0;
      r_data[hw]  = line(t);
      r_misses++;
    end else begin
      r_hits++;
    end
    r_lru = (hw == 0);
    if (wr) begin
      r_data[hw]  = wd;
      r_dirty[hw] = 1'b1;
    end

    cur_tag = t;
    wdata = wd;
    bus.mem_write = wr;
    bus.mem_read = ~wr;
    cyc = 0; done = 0; resp_cyc = -1; fill_cyc = -1;
    nwb = 0; nfill = 0; wcnt = 0;
    dly = $urandom_range(0, 3);
    while (!done && cyc < 60) begin
      smp();
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        if (wcnt == dly) begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) nwb++;
          else begin
            nfill++;
            fill_cyc = cyc;
          end
          wcnt = 0;
          dly = $urandom_range(0, 3);
        end else wcnt++;
      end
      if (bus.mem_resp) begin
        done = 1;
        resp_cyc = cyc;
      end
      tick();
      bus.pmem_resp = 1'b0;
      cyc++;
    end
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    chk("rnd_latency", resp_cyc, miss ? fill_cyc + 1 : 1);
    chk("rnd_writebacks", nwb, wb ? 1 : 0);
    chk("rnd_fills", nfill, miss ? 1 : 0);
    chk("rnd_flags", {e_valid, e_dirty, e_lru},
        {r_valid, r_dirty, r_lru});
    chk("rnd_tags", {e_tag[1], e_tag[0]}, {r_tag[1], r_tag[0]});
    chk("rnd_data", {e_data[1], e_data[0]},
        {r_data[1], r_data[0]});
  endtask

  initial begin
    dir = 1'b1;
    env_clr = 1'b1;
    d_hit = 2'b00;
    d_dirty = 2'b00;
    d_lru = 1'b0;
    cur_tag = 8'h00;
    wdata = 8'h00;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    rst = 1'b1;

    smp();
    chk("reset_outputs", outs(), 16'h0);
`ifdef CACHE_CTRL_PERF_EN
    chk("reset_counters", {bus.hit_count[15:0], bus.miss_count[15:0]}, 0);
`endif
    tick();
    rst = 1'b0;

    // read hit on way 0
    bus.mem_read = 1'b1;
    d_hit = 2'b01;
    smp(); chk("rd_hit_idle", outs(), 16'h0);
    tick(); smp();
    chk("rd_hit_check", outs(),
        o(1, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
    bus.mem_read = 1'b0;
    smp(); chk("rd_hit_after", outs(), 16'h0);

    // write hit on way 1
    bus.mem_write = 1'b1;
    d_hit = 2'b10;
    tick(); smp();
    chk("wr_hit_check", outs(),
        o(1, 0, 0, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b00, 2'b10));
    tick();

    // read+write with both ways hitting: write to way 0
    bus.mem_read = 1'b1;
    d_hit = 2'b11;
    tick(); smp();
    chk("rw_both_hit", outs(),
        o(1, 0, 0, 0, 0, 1, 1, 1, 2'b01, 2'b00, 2'b00, 2'b01));
    tick();
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;

    rst = 1'b1;
    smp();
    tick();
    rst = 1'b0;

    // clean read miss, victim way 1, fill after 5 cycles
    bus.mem_read = 1'b1;
    d_hit = 2'b00; d_lru = 1'b1; d_dirty = 2'b00;
    tick(); smp();
    chk("rm_check", outs(), 16'h0);
    tick();
    d_lru = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("rm_fetch_wait", outs(),
          o(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
      tick();
    end
    bus.pmem_resp = 1'b1;
    smp();
    chk("rm_fill", outs(),
        o(0, 1, 0, 0, 1, 0, 0, 0, 2'b10, 2'b10, 2'b10, 2'b10));
    tick();
    bus.pmem_resp = 1'b0;
    d_hit = 2'b10;
    smp();
    chk("rm_recheck", outs(),
        o(1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
    bus.mem_read = 1'b0;
    d_hit = 2'b00;
`ifdef CACHE_CTRL_PERF_EN
    chk("rm_miss_count", bus.miss_count, 1);
    chk("rm_hit_count", bus.hit_count, 0);
`endif

    // dirty write miss, victim way 0: writeback, fill, merge
    bus.mem_write = 1'b1;
    d_lru = 1'b0; d_dirty = 2'b01;
    tick(); smp();
    chk("wm_check", outs(), 16'h0);
    tick();
    d_lru = 1'b1;
    smp();
    chk("wm_writeback", outs(),
        o(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
    bus.pmem_resp = 1'b1;
    smp();
    chk("wm_wb_resp", outs(),
        o(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
    bus.pmem_resp = 1'b0;
    smp();
    chk("wm_fetch", outs(),
        o(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
    bus.pmem_resp = 1'b1;
    smp();
    chk("wm_fill", outs(),
        o(0, 1, 0, 0, 1, 0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b01));
    tick();
    bus.pmem_resp = 1'b0;
    d_hit = 2'b01; d_dirty = 2'b00;
    smp();
    chk("wm_merge", outs(),
        o(1, 0, 0, 0, 0, 1, 1, 1, 2'b01, 2'b00, 2'b00, 2'b01));
    tick();
    bus.mem_write = 1'b0;
    d_hit = 2'b00;

    // request withdrawn during the fill
    bus.mem_read = 1'b1;
    d_lru = 1'b0;
    tick(); tick();
    bus.mem_read = 1'b0;
    smp();
    chk("drop_fetch", outs(),
        o(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tick();
    bus.pmem_resp = 1'b1;
    smp();
    chk("drop_fill", outs(),
        o(0, 1, 0, 0, 1, 0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b01));
    tick();
    bus.pmem_resp = 1'b0;
    d_hit = 2'b01;
    smp(); chk("drop_check", outs(), 16'h0);
    tick();
    smp(); chk("drop_idle", outs(), 16'h0);
    tick();
    d_hit = 2'b00;

    // reset in the middle of a fill
    bus.mem_read = 1'b1;
    d_lru = 1'b1;
    tick(); tick();
    smp();
    chk("rst_fetch", outs(),
        o(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    bus.pmem_resp = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_fetch", outs(), 16'h0);
    tick();
    rst = 1'b0;
    bus.mem_read = 1'b0;
    smp(); chk("rst_stray_resp", outs(), 16'h0);
    tick();
    bus.pmem_resp = 1'b0;
    smp(); chk("rst_stay_idle", outs(), 16'h0);
    tick();

    // randomized traffic against the set model
    rst = 1'b1;
    env_clr = 1'b1;
    tick();
    rst = 1'b0;
    env_clr = 1'b0;
    dir = 1'b0;
    r_valid = 2'b00;
    r_dirty = 2'b00;
    r_lru = 1'b0;
    r_hits = 0;
    r_misses = 0;
    for (int w = 0; w < 2; w++) begin
      r_tag[w] = 8'h00;
      r_data[w] = 8'h00;
    end
    for (int i = 0; i < 40; i++) begin
      txn(8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          8'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end
`ifdef CACHE_CTRL_PERF_EN
    chk("rnd_hit_count", bus.hit_count, r_hits);
    chk("rnd_miss_count", bus.miss_count, r_misses);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter s_index, default 3, giving the index width of the sequenced arrays (8 sets).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 SHALL have port mem_write  input  1  CPU write request, held until mem_resp.
REQ-006 SHALL have port mem_resp  output  1  one-cycle CPU completion pulse.
REQ-007 SHALL have port hit  input  2  per-way tag match AND valid at current index.
REQ-008 SHALL have port lru_out  input  1  LRU array output, victim way.
REQ-009 SHALL have port dirty_out  input  2  per-way dirty bits at current index.
REQ-010 SHALL have port pmem_read / pmem_write  output  1 each  physical memory requests.
REQ-011 SHALL have port pmem_resp  input  1  physical memory completion pulse.
REQ-012 SHALL have port pmem_addr_sel  output  1  0 = CPU line address, 1 = victim tag address.
REQ-013 SHALL have ports data_load, tag_load, valid_load, dirty_load  output  2 each  per-way array load enables.
REQ-014 SHALL have port data_sel  output  1  0 = CPU write-merge data, 1 = pmem line.
REQ-015 SHALL have ports dirty_in, lru_load, lru_in  output  1 each  dirty/LRU array write controls.

Function
REQ-016 SHALL implement states IDLE, CHECK, WRITEBACK, FETCH; all outputs 0 unless stated.
REQ-017 IDLE: mem_read|mem_write -> CHECK next edge; else stay.
REQ-018 CHECK, no request: -> IDLE, no mem_resp, no loads.
REQ-019 CHECK, hit!=0: mem_resp=1 this cycle only; lru_load=1, lru_in=~way; -> IDLE.
REQ-020 CHECK hit on write: data_load[way]=1, data_sel=0, dirty_load[way]=1, dirty_in=1.
REQ-021 hit=2'b11 SHALL be treated as way 0; mem_read and mem_write together SHALL be treated as write.
REQ-022 CHECK, hit=0: register victim v=lru_out; -> WRITEBACK if dirty_out[v] else FETCH; no array loads.
REQ-023 WRITEBACK: pmem_write=1, pmem_addr_sel=1 held; on pmem_resp -> FETCH.
REQ-024 FETCH: pmem_read=1, pmem_addr_sel=0 held; on pmem_resp: data_load[v], tag_load[v], valid_load[v], dirty_load[v]=1, dirty_in=0, data_sel=1; -> CHECK.
REQ-025 Victim SHALL come from the register, never live lru_out, during WRITEBACK/FETCH.
REQ-026 pmem_resp SHALL be ignored in IDLE and CHECK.
REQ-027 Request dropped mid-miss: miss SHALL complete, then CHECK -> IDLE without mem_resp.
REQ-028 Latency: hit mem_resp 1 cycle after request; clean miss mem_resp 1 cycle after fill pmem_resp.
REQ-029 Outputs SHALL be combinational from state, victim register and inputs; arrays capture loads at the same edge.

Reset
REQ-030 rst SHALL asynchronously force IDLE, victim 0, all outputs 0, counters 0.
REQ-031 rst mid-WRITEBACK/FETCH SHALL drop pmem requests immediately with no array load.

Configuration
REQ-032 With CACHE_CTRL_PERF_EN defined, SHALL add outputs hit_count, miss_count (32 bits, wrapping): hit_count +1 per CHECK hit not immediately following FETCH; miss_count +1 per CHECK miss.
REQ-033 Without CACHE_CTRL_PERF_EN, those ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-034 Read, hit=01 -> mem_resp one cycle later, lru_load=1, lru_in=1, no pmem activity.
REQ-035 Write, hit=10 -> data_load=10, dirty_load=10, dirty_in=1, data_sel=0, mem_resp 1 cycle.
REQ-036 Read miss, lru_out=1, dirty_out=00, pmem_resp after 5 cycles -> FETCH loads way 1, dirty_in=0, re-CHECK hit -> mem_resp; miss_count=1, hit_count=0.
REQ-037 Write miss, lru_out=0, dirty_out=01 -> WRITEBACK with pmem_addr_sel=1, then FETCH, then write-hit merge into way 0.
REQ-038 rst asserted mid-FETCH -> pmem_read=0 same cycle, no loads, state IDLE; stray pmem_resp in IDLE ignored.
